// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
//
// Handshake: a requester raises <x>_req with <x>_we/<x>_addr/<x>_wdata stable
// and holds them until it sees the one-cycle <x>_gnt pulse. It may drop or
// change the request at the edge that ends the gnt cycle. Read data comes back
// as a one-cycle <x>_rvalid pulse with <x>_rdata, one cycle after the gnt.
// Dropping <x>_req before a gnt withdraws the request.
interface mem_arbiter_if #(
    parameter int MEM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_BYTES  = MEM_WIDTH / 8
);
    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [MEM_WIDTH-1:0]  a_wdata;
    logic                  a_gnt;
    logic                  a_rvalid;
    logic [MEM_WIDTH-1:0]  a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [MEM_WIDTH-1:0]  b_wdata;
    logic                  b_gnt;
    logic                  b_rvalid;
    logic [MEM_WIDTH-1:0]  b_rdata;

    logic [NUM_BYTES-1:0]  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [MEM_WIDTH-1:0]  mem_din;
    logic [MEM_WIDTH-1:0]  mem_dout;

    // Arbiter side
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    // Requester and memory side
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory (1-cycle read
// latency) between requesters A and B. The winner's fields are latched on the
// IDLE edge, so later changes on the request side cannot disturb the access.
module mem_arbiter #(
    parameter int MEM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_BYTES  = MEM_WIDTH / 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   bus,
    output logic [5:0]     state_leds
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;     // 0 = A, 1 = B
    logic                  prio_b_q, prio_b_d;   // 1 = B wins the next contention
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [MEM_WIDTH-1:0]  wdata_q, wdata_d;
    logic                  a_gnt_q, a_gnt_d;
    logic                  b_gnt_q, b_gnt_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic [NUM_BYTES-1:0]  mem_we_q, mem_we_d;
    logic                  pick_b;

    // Next state, latched access fields and next-cycle output decode
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        prio_b_d = prio_b_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        pick_b   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    // A lone requester always wins; priority only breaks ties
                    pick_b  = bus.b_req && (!bus.a_req || prio_b_q);
                    owner_d = pick_b;
                    addr_d  = pick_b ? bus.b_addr  : bus.a_addr;
                    we_d    = pick_b ? bus.b_we    : bus.a_we;
                    wdata_d = pick_b ? bus.b_wdata : bus.a_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // The requester just served loses the next tie
                prio_b_d = ~owner_q;
                state_d  = we_q ? IDLE : RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs decoded from the next state so they leave straight from flops
        a_gnt_d    = (state_d == ACCESS) && !owner_d;
        b_gnt_d    = (state_d == ACCESS) &&  owner_d;
        a_rvalid_d = (state_d == RESP)   && !owner_d;
        b_rvalid_d = (state_d == RESP)   &&  owner_d;
        mem_we_d   = {NUM_BYTES{(state_d == ACCESS) && we_d}};
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            prio_b_q   <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            mem_we_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_b_q   <= prio_b_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            mem_we_q   <= mem_we_d;
        end
    end

    // Memory port always shows the latched access, so it never glitches
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = wdata_q;

    // Read data is forced to zero whenever its valid is low
    assign bus.a_gnt    = a_gnt_q;
    assign bus.b_gnt    = b_gnt_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rdata  = a_rvalid_q ? bus.mem_dout : '0;
    assign bus.b_rdata  = b_rvalid_q ? bus.mem_dout : '0;

    assign state_leds = {2'b00, owner_q, prio_b_q, state_q};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, two queue-driven requesters and a
// transaction-level reference model of the arbitration schedule.
module tb_mem_arbiter;
    localparam int MW = 8;
    localparam int AW = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [MW-1:0] wdata;
    } op_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] state_leds;

    mem_arbiter_if #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .state_leds (state_leds)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory ----------------
    logic [MW-1:0] ram [0:255];
    always @(posedge clk) begin
        if (bus.mem_we[0]) ram[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= ram[bus.mem_addr];
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    op_t ops [2][$];
    bit  active [2];
    int  n_gnt [2];
    int  raw_gnt [2];
    int  n_rv [2];
    logic [MW-1:0] last_rdata [2];
    bit  gnt_log [$];
    int  gnt_cyc_log [$];
    bit  abort_en = 1'b0;
    int  pulse_mode = 0;
    bit  pulse_seen = 1'b0;
    logic [MW-1:0] fill [0:63];

    // ---------------- reference model ----------------
    logic [MW-1:0] ref_mem [0:255];
    logic [MW-1:0] exp_q [$];     // expected read data, in return order
    bit  m_prio_b;
    int  m_skip;                  // edges the arbiter still ignores requests
    bit  m_rd_pend;
    bit  m_rd_owner;
    bit  e_gnt [2];
    bit  e_rv [2];
    bit  e_wr;
    logic [AW-1:0] e_addr;
    logic [MW-1:0] e_din;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic op_t mk_op(input logic we, input logic [AW-1:0] addr, input logic [MW-1:0] wdata);
        op_t o;
        o.we = we;
        o.addr = addr;
        o.wdata = wdata;
        return o;
    endfunction

    task automatic model_reset();
        m_prio_b = 1'b0;
        m_skip = 0;
        m_rd_pend = 1'b0;
        m_rd_owner = 1'b0;
        exp_q.delete();
        e_gnt[0] = 0; e_gnt[1] = 0; e_rv[0] = 0; e_rv[1] = 0; e_wr = 0;
    endtask

    // One clock edge of the arbiter, seen as a transaction schedule: a sampled
    // request is granted next cycle; a write blocks one more edge, a read two,
    // and read data comes back the cycle after the grant.
    task automatic model_edge();
        bit  req_a, req_b, win;
        op_t op;
        req_a = bus.a_req;
        req_b = bus.b_req;
        e_gnt[0] = 0; e_gnt[1] = 0; e_rv[0] = 0; e_rv[1] = 0; e_wr = 0;
        if (m_rd_pend) begin
            e_rv[m_rd_owner] = 1;
            m_rd_pend = 0;
        end
        if (m_skip > 0) begin
            m_skip--;
        end else if (req_a || req_b) begin
            win = (req_a && req_b) ? m_prio_b : req_b;
            op = win ? mk_op(bus.b_we, bus.b_addr, bus.b_wdata)
                     : mk_op(bus.a_we, bus.a_addr, bus.a_wdata);
            e_gnt[win] = 1;
            e_addr = op.addr;
            e_din = op.wdata;
            m_prio_b = !win;
            if (op.we) begin
                e_wr = 1;
                ref_mem[op.addr] = op.wdata;
                m_skip = 1;
            end else begin
                exp_q.push_back(ref_mem[op.addr]);
                m_rd_pend = 1;
                m_rd_owner = win;
                m_skip = 2;
            end
        end
    endtask

    // ---------------- per-cycle scoreboard ----------------
    task automatic check_cycle();
        logic          rv;
        logic [MW-1:0] rd;
        check_eq("a_gnt", bus.a_gnt, e_gnt[0]);
        check_eq("b_gnt", bus.b_gnt, e_gnt[1]);
        check_eq("a_rvalid", bus.a_rvalid, e_rv[0]);
        check_eq("b_rvalid", bus.b_rvalid, e_rv[1]);
        check_eq("mem_we", bus.mem_we, e_wr);
        if (e_gnt[0] || e_gnt[1]) begin
            check_eq("mem_addr", bus.mem_addr, e_addr);
            if (e_wr) check_eq("mem_din", bus.mem_din, e_din);
        end
        if (bus.a_gnt) raw_gnt[0]++;
        if (bus.b_gnt) raw_gnt[1]++;
        for (int i = 0; i < 2; i++) begin
            rv = (i == 0) ? bus.a_rvalid : bus.b_rvalid;
            rd = (i == 0) ? bus.a_rdata  : bus.b_rdata;
            if (rv) begin
                n_rv[i]++;
                last_rdata[i] = rd;
                check_eq("exp_q_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) check_eq("rdata", rd, exp_q.pop_front());
            end else begin
                check_eq("rdata_idle", rd, 0);
            end
        end
    endtask

    // ---------------- requester drivers ----------------
    task automatic drive_reqs();
        op_t fa, fb;
        for (int i = 0; i < 2; i++) begin
            bit g, dropped;
            g = (i == 0) ? bus.a_gnt : bus.b_gnt;
            dropped = 0;
            if (active[i] && g) begin
                void'(ops[i].pop_front());
                active[i] = 0;
                n_gnt[i]++;
                gnt_log.push_back(i[0]);
                gnt_cyc_log.push_back(cyc);
            end else if (active[i] && abort_en && $urandom_range(0, 15) == 0) begin
                void'(ops[i].pop_front());
                active[i] = 0;
                dropped = 1;
            end
            if (!active[i] && !dropped && ops[i].size() > 0) active[i] = 1;
        end
        fa = active[0] ? ops[0][0] : op_t'(0);
        fb = active[1] ? ops[1][0] : op_t'(0);
        bus.a_req = active[0]; bus.a_we = fa.we; bus.a_addr = fa.addr; bus.a_wdata = fa.wdata;
        bus.b_req = active[1]; bus.b_we = fb.we; bus.b_addr = fb.addr; bus.b_wdata = fb.wdata;
        // One-cycle B request raised while A's read response is on the bus
        if (pulse_mode == 1 && bus.a_rvalid) begin
            bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h33;
            pulse_mode = 2;
            pulse_seen = 1'b1;
        end else if (pulse_mode == 2) begin
            pulse_mode = 0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
        drive_reqs();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((ops[0].size() > 0 || ops[1].size() > 0) && n < 400) begin
            step();
            n++;
        end
        check_eq({tag, "_drained"}, ops[0].size() + ops[1].size(), 0);
        repeat (4) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ops[0].delete(); ops[1].delete();
        active[0] = 0; active[1] = 0;
        pulse_mode = 0;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
        model_reset();
        #1;
        check_eq("rst_a_gnt", bus.a_gnt, 0);
        check_eq("rst_b_gnt", bus.b_gnt, 0);
        check_eq("rst_a_rvalid", bus.a_rvalid, 0);
        check_eq("rst_b_rvalid", bus.b_rvalid, 0);
        check_eq("rst_a_rdata", bus.a_rdata, 0);
        check_eq("rst_b_rdata", bus.b_rdata, 0);
        check_eq("rst_mem_we", bus.mem_we, 0);
        check_eq("rst_leds", state_leds, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int rv0, g0, g1, n;
        rst_n = 1'b1;
        #2;
        do_reset();

        // Prefill the low 64 words so every later read has a known value
        for (int i = 0; i < 64; i++) begin
            fill[i] = 8'($urandom_range(0, 255));
            ops[0].push_back(mk_op(1'b1, 8'(i), fill[i]));
        end
        drain("prefill");

        // A writes 0xA5 @0x10, then B reads it back
        rv0 = n_rv[0];
        ops[0].push_back(mk_op(1'b1, 8'h10, 8'hA5));
        drain("t2a");
        ops[1].push_back(mk_op(1'b0, 8'h10, 8'h00));
        drain("t2b");
        check_eq("t2_b_rdata", last_rdata[1], 8'hA5);
        check_eq("t2_no_a_rvalid", n_rv[0], rv0);

        // Top address write/read, bottom address untouched
        ops[0].push_back(mk_op(1'b1, 8'hFF, 8'h3C));
        ops[0].push_back(mk_op(1'b0, 8'hFF, 8'h00));
        drain("t6a");
        check_eq("t6_rdata_ff", last_rdata[0], 8'h3C);
        ops[0].push_back(mk_op(1'b0, 8'h00, 8'h00));
        drain("t6b");
        check_eq("t6_rdata_00", last_rdata[0], fill[0]);

        // Lone requester A, three back-to-back reads
        g0 = n_gnt[0];
        gnt_cyc_log.delete();
        for (int i = 0; i < 3; i++) ops[0].push_back(mk_op(1'b0, 8'(i + 4), 8'h00));
        drain("t4");
        check_eq("t4_grants", n_gnt[0] - g0, 3);
        check_eq("t4_log_size", gnt_cyc_log.size(), 3);
        if (gnt_cyc_log.size() == 3) begin
            check_eq("t4_spacing1", gnt_cyc_log[1] - gnt_cyc_log[0], 3);
            check_eq("t4_spacing2", gnt_cyc_log[2] - gnt_cyc_log[1], 3);
        end
        check_eq("t4_leds", state_leds, 6'b000100);

        // B pulses a request during A's response and drops it
        g1 = raw_gnt[1];
        pulse_seen = 1'b0;
        pulse_mode = 1;
        ops[0].push_back(mk_op(1'b0, 8'h10, 8'h00));
        drain("t5");
        check_eq("t5_pulse_driven", pulse_seen, 1);
        check_eq("t5_no_b_gnt", raw_gnt[1], g1);

        // Reset while A's read response is on the bus
        rv0 = n_rv[0];
        ops[0].push_back(mk_op(1'b0, 8'h20, 8'h00));
        n = 0;
        while (n_rv[0] == rv0 && n < 20) begin
            step();
            n++;
        end
        check_eq("t1_resp_reached", n_rv[0] - rv0, 1);
        do_reset();

        // Contention after reset: strict alternation starting with A
        g0 = n_gnt[0];
        g1 = n_gnt[1];
        gnt_log.delete();
        for (int i = 0; i < 4; i++) begin
            ops[0].push_back(mk_op(1'b0, 8'(8'h10 + i), 8'h00));
            ops[1].push_back(mk_op(1'b0, 8'(8'h20 + i), 8'h00));
        end
        drain("t3");
        check_eq("t3_a_count", n_gnt[0] - g0, 4);
        check_eq("t3_b_count", n_gnt[1] - g1, 4);
        check_eq("t3_log_size", gnt_log.size(), 8);
        for (int i = 0; i < gnt_log.size(); i++) check_eq("t3_order", gnt_log[i], i % 2);
        check_eq("t3_leds", state_leds, 6'b001000);

        // Random traffic with occasional withdrawn requests
        abort_en = 1'b1;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (ops[i].size() < 2 && $urandom_range(0, 2) == 0) begin
                    ops[i].push_back(mk_op(
                        1'($urandom_range(0, 1)),
                        ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15)),
                        8'($urandom_range(0, 255))));
                end
            end
            step();
        end
        abort_en = 1'b0;
        drain("rand");
        check_eq("rand_exp_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
